// File: rtl/reg_file_pkg.sv
// Shared constants for the integer register file and the write-back stage.
// Defines the sizes, the hardwired-zero index and the write-back select encoding.
package reg_file_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int ZERO_REG = 0;

    // Write-back select: bit WB_EN_BIT enables the write; the low bits pick the source
    localparam int WB_SEL_W  = 3;
    localparam int WB_EN_BIT = 2;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_NONE        = 3'b000,
        WB_RESULT      = 3'b100,
        WB_DATAMEM     = 3'b101,
        WB_CSR_DATAOUT = 3'b110
    } wb_sel_e;

    function automatic logic wb_sel_writes(input wb_sel_e sel);
        return sel[WB_EN_BIT];
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared by write-back.
// Optional macro REGFILE_BYPASS_EN hides the register being written this cycle from the stall.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = reg_file_pkg::NREGS,
    parameter int AW    = reg_file_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic          rs1_used,
    input  logic [AW-1:0] rs2_addr,
    input  logic          rs2_used,
    output logic          stall
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_eff;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == ZERO_REG) begin : g_zero
                always_ff @(posedge clk) begin
                    busy_reg[gi] <= 1'b0;
                end
            end else begin : g_bit
                // Set is checked first: a new issue is younger than the retiring writer
                always_ff @(posedge clk) begin
                    if (rst) begin
                        busy_reg[gi] <= 1'b0;
                    end else if (set_en && (set_addr == AW'(gi))) begin
                        busy_reg[gi] <= 1'b1;
                    end else if (clr_en && (clr_addr == AW'(gi))) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end

`ifdef REGFILE_BYPASS_EN
            assign busy_eff[gi] = busy_reg[gi] & ~(clr_en && (clr_addr == AW'(gi)));
`else
            assign busy_eff[gi] = busy_reg[gi];
`endif
        end
    endgenerate

    assign stall = (rs1_used & busy_eff[rs1_addr]) | (rs2_used & busy_eff[rs2_addr]);

endmodule

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one write-back port, hazard stall.
// Optional macro REGFILE_BYPASS_EN forwards write-back data to same-cycle reads.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN  = reg_file_pkg::XLEN,
    parameter int NREGS = reg_file_pkg::NREGS,
    parameter int AW    = reg_file_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [AW-1:0]   reg_addr,
    input  logic [XLEN-1:0] rdata,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    output logic            stall
);

    logic [XLEN-1:0] regs_reg [NREGS];
    logic            wr_valid;
    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;

    assign wr_valid = wen && (reg_addr != AW'(ZERO_REG));

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                always_ff @(posedge clk) begin
                    regs_reg[gi] <= '0;
                end
            end else begin : g_word
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_reg[gi] <= '0;
                    end else if (wr_valid && (reg_addr == AW'(gi))) begin
                        regs_reg[gi] <= rdata;
                    end
                end
            end
        end
    endgenerate

    assign rs1_stored = (rs1_addr == AW'(ZERO_REG)) ? '0 : regs_reg[rs1_addr];
    assign rs2_stored = (rs2_addr == AW'(ZERO_REG)) ? '0 : regs_reg[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    assign rs1_data = (wr_valid && (rs1_addr == reg_addr)) ? rdata : rs1_stored;
    assign rs2_data = (wr_valid && (rs2_addr == reg_addr)) ? rdata : rs2_stored;
`else
    assign rs1_data = rs1_stored;
    assign rs2_data = rs2_stored;
`endif

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (set_addr),
        .clr_en   (wen),
        .clr_addr (reg_addr),
        .rs1_addr (rs1_addr),
        .rs1_used (rs1_used),
        .rs2_addr (rs2_addr),
        .rs2_used (rs2_used),
        .stall    (stall)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: an architectural model predicts each cycle's outputs,
// queued at drive time and compared at the falling edge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  reg_addr;
    logic [31:0] rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        st;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .reg_addr (reg_addr),
        .rdata    (rdata),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .set_en   (set_en),
        .set_addr (set_addr),
        .stall    (stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t predict(input string tag);
        exp_t e;
        bit   b1;
        bit   b2;
        e.tag = tag;
        e.d1  = m_regs[rs1_addr];
        e.d2  = m_regs[rs2_addr];
        b1    = m_busy[rs1_addr];
        b2    = m_busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wen && reg_addr != 0 && rs1_addr == reg_addr) begin
            e.d1 = rdata;
            b1   = 1'b0;
        end
        if (wen && reg_addr != 0 && rs2_addr == reg_addr) begin
            e.d2 = rdata;
            b2   = 1'b0;
        end
`endif
        e.st = (rs1_used && b1) || (rs2_used && b2);
        return e;
    endfunction

    task automatic model_clock();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wen && reg_addr != 0) begin
                m_regs[reg_addr] = rdata;
                m_busy[reg_addr] = 1'b0;
            end
            if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit w, input logic [4:0] wa,
                        input logic [31:0] wd, input bit se, input logic [4:0] sa,
                        input logic [4:0] a1, input bit u1, input logic [4:0] a2, input bit u2);
        exp_t e;
        rst = r; wen = w; reg_addr = wa; rdata = wd;
        set_en = se; set_addr = sa;
        rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
        exp_q.push_back(predict(tag));
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({e.tag, ".rs1"}, rs1_data, e.d1);
        check_eq({e.tag, ".rs2"}, rs2_data, e.d2);
        check_eq({e.tag, ".stall"}, {31'h0, stall}, {31'h0, e.st});
        $display("%-10s rst=%0b wen=%0b wa=%0d wd=%h set=%0b sa=%0d rs1=%0d/%0b rs2=%0d/%0b -> %h %h stall=%0b",
                 tag, r, w, wa, wd, se, sa, a1, u1, a2, u2, rs1_data, rs2_data, stall);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; reg_addr = '0; rdata = '0;
        set_en = 1'b0; set_addr = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_clock();
        #1;

        //     tag         r  w  wa  wd             se sa  a1 u1 a2 u2
        step("rst_read",  0, 0, 0,  32'h0,         0, 0,  1, 1, 31, 1);
        step("wr5",       0, 1, 5,  32'hDEADBEEF,  0, 0,  5, 0, 5, 0);
        step("rd5",       0, 0, 0,  32'h0,         0, 0,  5, 0, 1, 0);
        step("wr0",       0, 1, 0,  32'hFFFFFFFF,  0, 0,  0, 0, 0, 0);
        step("rd0_set0",  0, 0, 0,  32'h0,         1, 0,  0, 1, 0, 1);
        step("rd0_stall", 0, 0, 0,  32'h0,         0, 0,  0, 1, 0, 1);
        step("set7",      0, 0, 0,  32'h0,         1, 7,  0, 0, 0, 0);
        step("haz7",      0, 0, 0,  32'h0,         0, 0,  0, 0, 7, 1);
        step("nouse7",    0, 0, 0,  32'h0,         0, 0,  0, 0, 7, 0);
        step("wb7",       0, 1, 7,  32'd42,        0, 0,  0, 0, 7, 1);
        step("rel7",      0, 0, 0,  32'h0,         0, 0,  0, 0, 7, 1);
        step("setclr9",   0, 1, 9,  32'h99,        1, 9,  9, 1, 0, 0);
        step("haz9",      0, 0, 0,  32'h0,         0, 0,  9, 1, 9, 0);
        step("set3",      0, 0, 0,  32'h0,         1, 3,  3, 1, 0, 0);
        step("rst3",      1, 1, 3,  32'd8,         0, 0,  3, 1, 0, 0);
        step("post3",     0, 0, 0,  32'h0,         0, 0,  3, 1, 3, 1);

        for (int i = 0; i < 200; i++) begin
            step($sformatf("rnd%0d", i),
                 ($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        if (exp_q.size() != 0) check_eq("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
